// File: rtl/tick_gen_if.sv
// Control, divisor-write and tick output bundle for tick_gen.
// The master drives enable, restart and divisor writes and receives the
// per-channel tick, square-wave and pending flags.
interface tick_gen_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 31
);
  logic              en;
  logic              clr;
  logic              wr_en;
  logic [3:0]        wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] pend;

  modport master (
    output en, clr, wr_en, wr_ch, wr_div,
    input  tick, sq, pend
  );

  modport slave (
    input  en, clr, wr_en, wr_ch, wr_div,
    output tick, sq, pend
  );
endinterface

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator. Each channel divides clk by its
// active divisor D, emitting a one-cycle tick every D enabled cycles and a
// square wave toggling on each tick. New divisors are staged in a shadow
// register and take effect at the channel's next wrap (or at once if the
// channel is stopped, on a wrap-cycle write, or on clr). D = 0 stops a channel.
module tick_gen #(
  parameter int unsigned                 NUM_CH  = 3,
  parameter int unsigned                 CNT_W   = 31,
  parameter logic [NUM_CH*CNT_W-1:0]     DEF_DIV = {31'd2000000000, 31'd100000000, 31'd1048576}
) (
  input  logic     clk,
  input  logic     rst_n,
  tick_gen_if.slave bus
);

  logic [1:0]        rst_sync_q;
  logic              rst_int_n;

  logic [CNT_W-1:0]  cnt_q     [NUM_CH];
  logic [CNT_W-1:0]  cnt_d     [NUM_CH];
  logic [CNT_W-1:0]  act_div_q [NUM_CH];
  logic [CNT_W-1:0]  act_div_d [NUM_CH];
  logic [CNT_W-1:0]  shd_div_q [NUM_CH];
  logic [CNT_W-1:0]  shd_div_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] running;

  // Reset asserts asynchronously and releases two clock edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Per-channel write decode and wrap detection; D = 0 is excluded before the
  // subtract so act_div - 1 never underflows.
  always_comb begin
    wr_hit  = '0;
    wrap    = '0;
    running = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_hit[i]  = bus.wr_en && (32'(bus.wr_ch) == i);
      running[i] = (act_div_q[i] != '0);
      wrap[i]    = bus.en && running[i] && (cnt_q[i] == (act_div_q[i] - CNT_W'(1)));
    end
  end

  // Next-state for every channel: clr, then write-on-stopped / wrap, then hold/count.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i]     = cnt_q[i];
      act_div_d[i] = act_div_q[i];
      shd_div_d[i] = shd_div_q[i];
      pend_d[i]    = pend_q[i];
      tick_d[i]    = 1'b0;
      sq_d[i]      = sq_q[i];

      if (bus.clr) begin
        cnt_d[i]  = '0;
        sq_d[i]   = 1'b0;
        pend_d[i] = 1'b0;
        if (wr_hit[i]) begin
          act_div_d[i] = bus.wr_div;
          shd_div_d[i] = bus.wr_div;
        end else if (pend_q[i]) begin
          act_div_d[i] = shd_div_q[i];
        end
      end else if (wr_hit[i] && !running[i]) begin
        act_div_d[i] = bus.wr_div;
        shd_div_d[i] = bus.wr_div;
        cnt_d[i]     = '0;
        pend_d[i]    = 1'b0;
      end else if (wrap[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        sq_d[i]   = ~sq_q[i];
        pend_d[i] = 1'b0;
        if (wr_hit[i]) begin
          act_div_d[i] = bus.wr_div;
          shd_div_d[i] = bus.wr_div;
        end else if (pend_q[i]) begin
          act_div_d[i] = shd_div_q[i];
        end
      end else begin
        if (wr_hit[i]) begin
          shd_div_d[i] = bus.wr_div;
          pend_d[i]    = 1'b1;
        end
        if (bus.en && running[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Channel state registers, reset to the DEF_DIV divisors.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]     <= '0;
        act_div_q[i] <= DEF_DIV[i*CNT_W +: CNT_W];
        shd_div_q[i] <= DEF_DIV[i*CNT_W +: CNT_W];
      end
      pend_q <= '0;
      tick_q <= '0;
      sq_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]     <= cnt_d[i];
        act_div_q[i] <= act_div_d[i];
        shd_div_q[i] <= shd_div_d[i];
      end
      pend_q <= pend_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign bus.tick = tick_q;
  assign bus.sq   = sq_q;
  assign bus.pend = pend_q;

endmodule
